// File: rtl/ipbus_axis_pkt_loopback_pkg.sv
// Shared types and constants for the IPbus AXI4-Stream store-and-forward loopback buffer.
package ipbus_axis_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_SIDE_W = 4;
  localparam int DROP_CNT_W  = 16;

  typedef enum logic {
    STORE = 1'b0,
    DROP  = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic                   tlast;
    logic [AXIS_SIDE_W-1:0] tdest;
    logic [AXIS_SIDE_W-1:0] tid;
    logic [AXIS_SIDE_W-1:0] tkeep;
    logic [AXIS_DATA_W-1:0] tdata;
  } axis_beat_t;

  localparam int BEAT_W = $bits(axis_beat_t);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ipbus_axis_pkt_loopback_if.sv
// AXI4-Stream bundle; master drives the beat, slave returns tready.
interface ipbus_axis_pkt_loopback_if;
  import ipbus_axis_pkg::*;

  logic                   tvalid;
  logic                   tready;
  logic [AXIS_DATA_W-1:0] tdata;
  logic [AXIS_SIDE_W-1:0] tkeep;
  logic [AXIS_SIDE_W-1:0] tstrb;
  logic [AXIS_SIDE_W-1:0] tid;
  logic [AXIS_SIDE_W-1:0] tdest;
  logic                   tlast;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tid, tdest, tlast,
    input  tready
  );

  // tstrb is regenerated from tkeep on the output side, so the receiver never reads it
  modport slave (
    input  tvalid, tdata, tkeep, tid, tdest, tlast,
    output tready
  );

endinterface

// File: rtl/ipbus_axis_pkt_loopback_ram.sv
// Simple dual-port beat store: synchronous write, asynchronous read for fall-through output.
module axis_pkt_buf_ram
  import ipbus_axis_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  axis_beat_t        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output axis_beat_t        rdata_o
);

  logic [BEAT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = axis_beat_t'(mem_q[raddr_i]);

endmodule

// File: rtl/ipbus_axis_pkt_loopback.sv
// Store-and-forward packet loopback from the IPbus stream output back to its stream input.
// Oversize packets are discarded in DROP so a packet larger than the buffer can never deadlock it.
module ipbus_axis_pkt_loopback
  import ipbus_axis_pkg::*;
#(
  parameter  int DEPTH  = 512,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ipbus_axis_pkt_loopback_if.slave  s_axis,
  ipbus_axis_pkt_loopback_if.master m_axis,
  output logic [ADDR_W:0]       pkt_count_o,
  output logic [DROP_CNT_W-1:0] drop_count_o,
  output logic                  overflow_o
);

  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  wr_state_e             state_q, state_d;
  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  wr_commit_q, wr_commit_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  ptr_t                  pkt_count_q, pkt_count_d;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

  logic       full;
  logic       avail;
  logic       s_tready;
  logic       wr_en;
  logic       commit;
  logic       rd_fire;
  logic       rd_last;
  axis_beat_t wr_beat;
  axis_beat_t rd_beat;

  // full looks only at registered pointers, so a same-cycle read never enables a write
  assign full  = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign avail = rd_ptr_q != wr_commit_q;

  assign wr_beat = '{
    tlast: s_axis.tlast,
    tdest: s_axis.tdest,
    tid:   s_axis.tid,
    tkeep: s_axis.tkeep,
    tdata: s_axis.tdata
  };

  axis_pkt_buf_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (wr_beat),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rd_beat)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    drop_count_d = drop_count_q;
    s_tready     = 1'b0;
    wr_en        = 1'b0;
    commit       = 1'b0;

    unique case (state_q)
      STORE: begin
        s_tready = !full;
        if (full && (wr_commit_q == rd_ptr_q)) begin
          // the unfinished packet alone fills the buffer: rewind it and discard the rest
          state_d  = DROP;
          wr_ptr_d = wr_commit_q;
        end else if (s_axis.tvalid && !full) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ptr_t'(1);
          if (s_axis.tlast) begin
            wr_commit_d = wr_ptr_q + ptr_t'(1);
            commit      = 1'b1;
          end
        end
      end
      DROP: begin
        s_tready = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) begin
          state_d      = STORE;
          drop_count_d = sat_inc(drop_count_q);
        end
      end
      default: state_d = STORE;
    endcase
  end

  always_comb begin
    rd_fire  = avail && m_axis.tready;
    rd_last  = rd_fire && rd_beat.tlast;
    rd_ptr_d = rd_fire ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;

    pkt_count_d = pkt_count_q;
    unique case ({commit, rd_last})
      2'b10:   pkt_count_d = pkt_count_q + ptr_t'(1);
      2'b01:   pkt_count_d = pkt_count_q - ptr_t'(1);
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= STORE;
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      rd_ptr_q     <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign s_axis.tready = s_tready;

  assign m_axis.tvalid = avail;
  assign m_axis.tdata  = rd_beat.tdata;
  assign m_axis.tkeep  = rd_beat.tkeep;
  assign m_axis.tstrb  = rd_beat.tkeep;
  assign m_axis.tid    = rd_beat.tid;
  assign m_axis.tdest  = rd_beat.tdest;
  assign m_axis.tlast  = rd_beat.tlast;

  assign pkt_count_o  = pkt_count_q;
  assign drop_count_o = drop_count_q;
  assign overflow_o   = (state_q == DROP);

endmodule

// File: tb/tb_ipbus_axis_pkt_loopback.sv
// Directed bench for the loopback buffer at DEPTH=16: forwarding, latency, full stall, drop and reset.
module tb_ipbus_axis_pkt_loopback;
  import ipbus_axis_pkg::*;

  typedef struct packed {
    logic [3:0] strb;
    axis_beat_t beat;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] pkt_count;
  logic [DROP_CNT_W-1:0] drop_count;
  logic       overflow;

  int n_chk  = 0;
  int n_fail = 0;

  axis_beat_t in_q[$];
  axis_beat_t exp_q[$];
  obs_t       got_q[$];

  ipbus_axis_pkt_loopback_if s_if ();
  ipbus_axis_pkt_loopback_if m_if ();

  ipbus_axis_pkt_loopback #(.DEPTH(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .pkt_count_o  (pkt_count),
    .drop_count_o (drop_count),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_s();
    s_if.tstrb = '0;
    if (in_q.size() > 0) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = in_q[0].tdata;
      s_if.tkeep  = in_q[0].tkeep;
      s_if.tid    = in_q[0].tid;
      s_if.tdest  = in_q[0].tdest;
      s_if.tlast  = in_q[0].tlast;
    end else begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tid    = '0;
      s_if.tdest  = '0;
      s_if.tlast  = 1'b0;
    end
  endtask

  int ovf_cycles;
  logic rdy_low_seen;

  // one clock: note handshakes before the edge, then update the sender after it
  task automatic tick();
    logic s_hs, m_hs;
    obs_t o;
    #1;
    s_hs = s_if.tvalid && s_if.tready;
    m_hs = m_if.tvalid && m_if.tready;
    if (overflow) ovf_cycles++;
    if (s_if.tvalid && !s_if.tready) rdy_low_seen = 1'b1;
    if (m_hs) begin
      o.strb       = m_if.tstrb;
      o.beat.tlast = m_if.tlast;
      o.beat.tdest = m_if.tdest;
      o.beat.tid   = m_if.tid;
      o.beat.tkeep = m_if.tkeep;
      o.beat.tdata = m_if.tdata;
      got_q.push_back(o);
    end
    @(posedge clk);
    #1;
    if (s_hs) void'(in_q.pop_front());
    drive_s();
  endtask

  task automatic push_pkt(input int n, input logic [31:0] base, input logic [3:0] tid,
                          input logic [3:0] tdest, input logic [3:0] last_keep, input bit expect_out);
    axis_beat_t b;
    for (int i = 0; i < n; i++) begin
      b.tdata = base + 32'(i);
      b.tid   = tid;
      b.tdest = tdest;
      b.tlast = (i == n - 1);
      b.tkeep = (i == n - 1) ? last_keep : 4'hF;
      in_q.push_back(b);
      if (expect_out) exp_q.push_back(b);
    end
  endtask

  task automatic cmp_out(input string tag);
    chk({tag, "_nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_beat%0d", tag, i), 64'(got_q[i].beat), 64'(exp_q[i]));
      chk($sformatf("%s_strb%0d", tag, i), 64'(got_q[i].strb), 64'(exp_q[i].tkeep));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    m_if.tready = 1'b0;
    drive_s();
    tick();
    tick();
    chk("rst_s_tready", 64'(s_if.tready), 64'd1);
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_pkt",      64'(pkt_count),   64'd0);
    chk("rst_drop",     64'(drop_count),  64'd0);
    chk("rst_ovf",      64'(overflow),    64'd0);
    rst = 1'b0;
    tick();

    // single 5-beat packet, sink always ready
    m_if.tready = 1'b1;
    push_pkt(5, 32'h1, 4'd3, 4'd7, 4'hF, 1'b1);
    drive_s();
    for (int i = 0; i < 20 && in_q.size() > 1; i++) tick();
    chk("p1_tlast_front", 64'(in_q.size()), 64'd1);
    chk("p1_vld_before",  64'(m_if.tvalid), 64'd0);
    tick();
    chk("p1_vld_after",   64'(m_if.tvalid), 64'd1);
    chk("p1_pkt_one",     64'(pkt_count),   64'd1);
    for (int i = 0; i < 20 && got_q.size() < 5; i++) tick();
    chk("p1_pkt_zero",    64'(pkt_count),   64'd0);
    chk("p1_vld_idle",    64'(m_if.tvalid), 64'd0);
    cmp_out("p1");

    // three back-to-back packets held, then released
    m_if.tready = 1'b0;
    push_pkt(4, 32'h10, 4'd1, 4'd2, 4'h3, 1'b1);
    push_pkt(4, 32'h20, 4'd4, 4'd5, 4'h1, 1'b1);
    push_pkt(4, 32'h30, 4'd6, 4'd8, 4'h7, 1'b1);
    drive_s();
    for (int i = 0; i < 40 && in_q.size() > 0; i++) tick();
    chk("p3_sent",   64'(in_q.size()), 64'd0);
    chk("p3_pkt",    64'(pkt_count),   64'd3);
    chk("p3_rdy",    64'(s_if.tready), 64'd1);
    m_if.tready = 1'b1;
    for (int i = 0; i < 40 && got_q.size() < 12; i++) tick();
    chk("p3_pkt_end", 64'(pkt_count), 64'd0);
    cmp_out("p3");

    // exactly DEPTH beats: accepted whole, then tready low until drained
    m_if.tready  = 1'b0;
    rdy_low_seen = 1'b0;
    ovf_cycles   = 0;
    push_pkt(16, 32'h100, 4'd9, 4'd1, 4'hF, 1'b1);
    drive_s();
    for (int i = 0; i < 40 && in_q.size() > 0; i++) tick();
    chk("full_sent",      64'(in_q.size()),  64'd0);
    chk("full_rdy_hold",  64'(rdy_low_seen), 64'd0);
    chk("full_rdy_low",   64'(s_if.tready),  64'd0);
    chk("full_pkt",       64'(pkt_count),    64'd1);
    tick();
    tick();
    chk("full_no_ovf",    64'(ovf_cycles),   64'd0);
    m_if.tready = 1'b1;
    for (int i = 0; i < 40 && got_q.size() < 16; i++) tick();
    chk("full_drop",      64'(drop_count),   64'd0);
    chk("full_rdy_back",  64'(s_if.tready),  64'd1);
    cmp_out("full");

    // 20-beat packet into an empty buffer is dropped; next packet passes
    ovf_cycles = 0;
    push_pkt(20, 32'h200, 4'd2, 4'd3, 4'hF, 1'b0);
    drive_s();
    for (int i = 0; i < 60 && in_q.size() > 0; i++) tick();
    chk("ovr_sent",    64'(in_q.size()), 64'd0);
    chk("ovr_cycles",  64'(ovf_cycles),  64'd4);
    chk("ovr_drop",    64'(drop_count),  64'd1);
    chk("ovr_pkt",     64'(pkt_count),   64'd0);
    chk("ovr_ovf_end", 64'(overflow),    64'd0);
    chk("ovr_nothing", 64'(got_q.size()), 64'd0);
    push_pkt(3, 32'h300, 4'd5, 4'd6, 4'h3, 1'b1);
    drive_s();
    for (int i = 0; i < 30 && got_q.size() < 3; i++) tick();
    cmp_out("post");

    // 8 committed words + oversize packet: stall at full, drain, then drop
    m_if.tready  = 1'b0;
    ovf_cycles   = 0;
    push_pkt(8, 32'h400, 4'd7, 4'd4, 4'hF, 1'b1);
    push_pkt(20, 32'h500, 4'd8, 4'd9, 4'hF, 1'b0);
    drive_s();
    for (int i = 0; i < 40 && s_if.tready; i++) tick();
    chk("stall_rdy",  64'(s_if.tready),  64'd0);
    chk("stall_left", 64'(in_q.size()),  64'd12);
    chk("stall_pkt",  64'(pkt_count),    64'd1);
    tick();
    tick();
    tick();
    chk("stall_hold", 64'(s_if.tready),  64'd0);
    chk("stall_ovf",  64'(ovf_cycles),   64'd0);
    m_if.tready = 1'b1;
    for (int i = 0; i < 80 && in_q.size() > 0; i++) tick();
    chk("stall_sent", 64'(in_q.size()),  64'd0);
    chk("stall_drop", 64'(drop_count),   64'd2);
    chk("stall_pkt0", 64'(pkt_count),    64'd0);
    chk("stall_dropped", 64'(ovf_cycles > 0), 64'd1);
    chk("stall_vld",  64'(m_if.tvalid),  64'd0);
    cmp_out("stall");

    // reset in the middle of a packet with two packets stored
    m_if.tready = 1'b0;
    push_pkt(3, 32'h600, 4'd1, 4'd1, 4'hF, 1'b0);
    push_pkt(3, 32'h700, 4'd2, 4'd2, 4'hF, 1'b0);
    push_pkt(6, 32'h800, 4'd3, 4'd3, 4'hF, 1'b0);
    drive_s();
    for (int i = 0; i < 8; i++) tick();
    chk("mrst_pre_pkt", 64'(pkt_count), 64'd2);
    in_q.delete();
    drive_s();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_pkt",  64'(pkt_count),   64'd0);
    chk("mrst_drop", 64'(drop_count),  64'd0);
    chk("mrst_vld",  64'(m_if.tvalid), 64'd0);
    chk("mrst_rdy",  64'(s_if.tready), 64'd1);
    chk("mrst_ovf",  64'(overflow),    64'd0);
    m_if.tready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("mrst_no_out", 64'(got_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
